// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use bubble, taken-branch flush, multi-cycle op throttling.
// Optional macro HAZARD_SCOREBOARD_EN adds a per-register pending-write scoreboard for multi-cycle ops.
module hazard_ctrl #(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned NUM_SRC      = 2,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MC_MAX_OUT   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SRC*REG_AW-1:0]   rs_addr_ex,
  input  logic [NUM_SRC*REG_AW-1:0]   rs_addr_dec,
  input  logic [REG_AW-1:0]           rd_addr_ex,
  input  logic                        mem_read_ex,
  input  logic [REG_AW-1:0]           rd_addr_mem,
  input  logic                        rd_write_mem,
  input  logic [REG_AW-1:0]           rd_addr_wb,
  input  logic                        rd_write_wb,
  input  logic                        taken,
  input  logic                        mc_issue,
  input  logic [REG_AW-1:0]           mc_rd,
  input  logic                        mc_done,
  input  logic [REG_AW-1:0]           mc_done_rd,
  output logic [NUM_SRC*2-1:0]        fwd_ctrl,
  output logic                        pc_stall,
  output logic                        stall_dec,
  output logic                        flush_fe,
  output logic                        flush_dec,
  output logic                        flush_ex,
  output logic [3:0]                  mc_outstanding
);

  localparam logic [1:0] RS_DATA = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int unsigned FC_W   = 3;
  localparam int unsigned MC_W   = 4;
  localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [MC_W-1:0] MC_MAX       = MC_W'(MC_MAX_OUT);

  logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [MC_W-1:0] mc_cnt_q, mc_cnt_d;

  logic flushing;
  logic mc_full;
  logic issue_ok;
  logic done_ok;
  logic load_use_match;
  logic dec_nonzero;
  logic mc_hazard;

  // Forwarding select per execute source; register 0 never forwards
  always_comb begin
    fwd_ctrl = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_ctrl[i*2 +: 2] = RS_DATA;
      if (rst_n && (rs_addr_ex[i*REG_AW +: REG_AW] != '0)) begin
        if (rd_write_mem && (rs_addr_ex[i*REG_AW +: REG_AW] == rd_addr_mem)) begin
          fwd_ctrl[i*2 +: 2] = FWD_MEM;
        end else if (rd_write_wb && (rs_addr_ex[i*REG_AW +: REG_AW] == rd_addr_wb)) begin
          fwd_ctrl[i*2 +: 2] = FWD_WB;
        end
      end
    end
  end

`ifdef HAZARD_SCOREBOARD_EN
  localparam int unsigned NREG = 1 << REG_AW;
  logic [NREG-1:0] sb_q, sb_d;
  logic            sb_hit;

  always_comb begin
    sb_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if ((rs_addr_dec[i*REG_AW +: REG_AW] != '0) && sb_q[rs_addr_dec[i*REG_AW +: REG_AW]]) begin
        sb_hit = 1'b1;
      end
    end
  end

  // Clear applied before set so a same-cycle set/clear on one register leaves it pending
  always_comb begin
    sb_d = sb_q;
    if (mc_done) begin
      sb_d[mc_done_rd] = 1'b0;
    end
    if (issue_ok && (mc_rd != '0)) begin
      sb_d[mc_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  assign mc_hazard = sb_hit;
`else
  logic unused_sb;
  assign unused_sb = ^{mc_rd, mc_done_rd};
  assign mc_hazard = (mc_cnt_q != '0) && dec_nonzero;
`endif

  always_comb begin
    load_use_match = 1'b0;
    dec_nonzero    = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rs_addr_dec[i*REG_AW +: REG_AW] != '0) begin
        dec_nonzero = 1'b1;
        if (rs_addr_dec[i*REG_AW +: REG_AW] == rd_addr_ex) begin
          load_use_match = 1'b1;
        end
      end
    end
  end

  assign flushing = rst_n && (taken || (flush_cnt_q != '0));
  assign mc_full  = (mc_cnt_q == MC_MAX);
  assign issue_ok = mc_issue && !mc_full;
  assign done_ok  = mc_done && (mc_cnt_q != '0);

  // A flush in progress suppresses every stall and the load-use bubble
  always_comb begin
    pc_stall       = 1'b0;
    stall_dec      = 1'b0;
    flush_ex       = 1'b0;
    flush_fe       = flushing;
    flush_dec      = flushing;
    mc_outstanding = mc_cnt_q;
    if (rst_n && !flushing) begin
      flush_ex  = mem_read_ex && load_use_match;
      pc_stall  = (mem_read_ex && load_use_match) || mc_full || mc_hazard;
      stall_dec = pc_stall;
    end
  end

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (taken) begin
      flush_cnt_d = FLUSH_RELOAD;
    end else if (flush_cnt_q != '0) begin
      flush_cnt_d = flush_cnt_q - FC_W'(1);
    end
  end

  always_comb begin
    mc_cnt_d = mc_cnt_q;
    if (issue_ok && !done_ok) begin
      mc_cnt_d = mc_cnt_q + MC_W'(1);
    end else if (done_ok && !issue_ok) begin
      mc_cnt_d = mc_cnt_q - MC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_q <= '0;
      mc_cnt_q    <= '0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      mc_cnt_q    <= mc_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_hazard_ctrl;

  localparam int AW   = 5;
  localparam int NS   = 2;
  localparam int FC   = 3;
  localparam int MCMX = 2;

  localparam int RS_DATA = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_WB  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NS*AW-1:0]     rs_addr_ex, rs_addr_dec;
  logic [AW-1:0]        rd_addr_ex, rd_addr_mem, rd_addr_wb, mc_rd, mc_done_rd;
  logic                 mem_read_ex, rd_write_mem, rd_write_wb, taken, mc_issue, mc_done;
  logic [NS*2-1:0]      fwd_ctrl;
  logic                 pc_stall, stall_dec, flush_fe, flush_dec, flush_ex;
  logic [3:0]           mc_outstanding;

  hazard_ctrl #(.REG_AW(AW), .NUM_SRC(NS), .FLUSH_CYCLES(FC), .MC_MAX_OUT(MCMX)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_addr_ex(rs_addr_ex), .rs_addr_dec(rs_addr_dec),
    .rd_addr_ex(rd_addr_ex), .mem_read_ex(mem_read_ex),
    .rd_addr_mem(rd_addr_mem), .rd_write_mem(rd_write_mem),
    .rd_addr_wb(rd_addr_wb), .rd_write_wb(rd_write_wb),
    .taken(taken), .mc_issue(mc_issue), .mc_rd(mc_rd),
    .mc_done(mc_done), .mc_done_rd(mc_done_rd),
    .fwd_ctrl(fwd_ctrl), .pc_stall(pc_stall), .stall_dec(stall_dec),
    .flush_fe(flush_fe), .flush_dec(flush_dec), .flush_ex(flush_ex),
    .mc_outstanding(mc_outstanding)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: cycles of flush still owed, ops in flight, registers awaiting a write
  int m_flush_left;
  int m_out;
  bit m_pend [32];

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int src_of(input logic [NS*AW-1:0] v, input int i);
    return int'((v >> (i*AW)) & {{(NS*AW-AW){1'b0}}, {AW{1'b1}}});
  endfunction

  task automatic model_reset();
    m_flush_left = 0;
    m_out = 0;
    foreach (m_pend[r]) m_pend[r] = 1'b0;
  endtask

  task automatic check_outputs();
    int exp_fwd, a, sel;
    bit fl, lu, hz, stall;
    exp_fwd = 0;
    fl = 0; lu = 0; hz = 0; stall = 0;
    if (rst_n) begin
      for (int i = 0; i < NS; i++) begin
        a = src_of(rs_addr_ex, i);
        sel = RS_DATA;
        if (a != 0 && rd_write_mem && a == int'(rd_addr_mem)) sel = FWD_MEM;
        else if (a != 0 && rd_write_wb && a == int'(rd_addr_wb)) sel = FWD_WB;
        exp_fwd += sel << (2*i);
      end
      fl = taken || (m_flush_left > 0);
      for (int i = 0; i < NS; i++) begin
        a = src_of(rs_addr_dec, i);
        if (mem_read_ex && rd_addr_ex != 0 && a == int'(rd_addr_ex)) lu = 1;
`ifdef HAZARD_SCOREBOARD_EN
        if (a != 0 && m_pend[a]) hz = 1;
`else
        if (a != 0 && m_out != 0) hz = 1;
`endif
      end
      stall = !fl && (lu || (m_out == MCMX) || hz);
    end
    chk("fwd_ctrl", int'(fwd_ctrl), exp_fwd);
    chk("pc_stall", int'(pc_stall), int'(stall));
    chk("stall_dec", int'(stall_dec), int'(stall));
    chk("flush_fe", int'(flush_fe), int'(fl));
    chk("flush_dec", int'(flush_dec), int'(fl));
    chk("flush_ex", int'(flush_ex), int'(!fl && lu));
    chk("mc_outstanding", int'(mc_outstanding), rst_n ? m_out : 0);
  endtask

  task automatic model_update();
    bit iss, dn;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (taken) m_flush_left = FC - 1;
    else if (m_flush_left > 0) m_flush_left--;
    iss = mc_issue && (m_out < MCMX);
    dn  = mc_done && (m_out > 0);
    m_out = m_out + int'(iss) - int'(dn);
    if (mc_done) m_pend[mc_done_rd] = 1'b0;
    if (iss && mc_rd != 0) m_pend[mc_rd] = 1'b1;
  endtask

  task automatic run_cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    rs_addr_ex = '0; rs_addr_dec = '0; rd_addr_ex = '0; mem_read_ex = 0;
    rd_addr_mem = '0; rd_write_mem = 0; rd_addr_wb = '0; rd_write_wb = 0;
    taken = 0; mc_issue = 0; mc_rd = '0; mc_done = 0; mc_done_rd = '0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) != 0) return AW'($urandom_range(0, 3));
    return AW'($urandom_range(0, 31));
  endfunction

  task automatic rand_inputs();
    rs_addr_ex   = {rnd_addr(), rnd_addr()};
    rs_addr_dec  = {rnd_addr(), rnd_addr()};
    rd_addr_ex   = rnd_addr();
    mem_read_ex  = 1'($urandom_range(0, 1));
    rd_addr_mem  = rnd_addr();
    rd_write_mem = 1'($urandom_range(0, 1));
    rd_addr_wb   = rnd_addr();
    rd_write_wb  = 1'($urandom_range(0, 1));
    taken        = ($urandom_range(0, 7) == 0);
    mc_issue     = ($urandom_range(0, 2) == 0);
    mc_rd        = rnd_addr();
    mc_done      = ($urandom_range(0, 2) == 0);
    mc_done_rd   = rnd_addr();
    rst_n        = ($urandom_range(0, 99) != 0);
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    model_reset();
    taken = 1;
    rs_addr_ex = {5'd0, 5'd5}; rd_addr_mem = 5'd5; rd_write_mem = 1;
    repeat (2) run_cycle();
    idle_inputs();
    rst_n = 1;
    run_cycle();

    // Forwarding priority MEM over WB, then WB alone, then register 0
    rs_addr_ex = {5'd0, 5'd5}; rd_addr_mem = 5'd5; rd_write_mem = 1; rd_addr_wb = 5'd5; rd_write_wb = 1;
    run_cycle();
    rd_write_mem = 0;
    run_cycle();
    rs_addr_ex = '0; rd_addr_mem = '0; rd_write_mem = 1;
    run_cycle();
    idle_inputs();

    // Load-use bubble, then same hazard with a taken branch overriding it
    mem_read_ex = 1; rd_addr_ex = 5'd7; rs_addr_dec = {5'd7, 5'd0};
    run_cycle();
    mem_read_ex = 0;
    run_cycle();
    mem_read_ex = 1; taken = 1;
    run_cycle();
    idle_inputs();
    repeat (3) run_cycle();

    // Back-to-back taken extends the flush window
    taken = 1; run_cycle();
    taken = 1; run_cycle();
    taken = 0; repeat (4) run_cycle();

    // Multi-cycle ops: fill, overflow attempt, simultaneous issue/done, drain, underflow attempt
    mc_issue = 1; mc_rd = 5'd9; run_cycle();
    mc_rd = 5'd3; run_cycle();
    mc_rd = 5'd4; run_cycle();
    mc_done = 1; mc_done_rd = 5'd3; mc_rd = 5'd4; run_cycle();
    mc_issue = 0; rs_addr_dec = {5'd0, 5'd9}; mc_done_rd = 5'd4; run_cycle();
    mc_done = 0; run_cycle();
    rs_addr_dec = {5'd0, 5'd10}; run_cycle();
    rs_addr_dec = {5'd0, 5'd9}; run_cycle();
    mc_done = 1; mc_done_rd = 5'd9; run_cycle();
    mc_done = 0; run_cycle();
    mc_done = 1; run_cycle();
    mc_done = 0; run_cycle();

    // Reset asserted mid-stall must drop every control at once
    mc_issue = 1; mc_rd = 5'd9; run_cycle();
    mc_issue = 0; taken = 1; run_cycle();
    taken = 0;
    rst_n = 0;
    #1;
    chk("rst_pc_stall", int'(pc_stall), 0);
    chk("rst_flush_fe", int'(flush_fe), 0);
    chk("rst_mc_out", int'(mc_outstanding), 0);
    run_cycle();
    rst_n = 1;
    repeat (2) run_cycle();

    for (int c = 0; c < 2000; c++) begin
      rand_inputs();
      run_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
